// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 (7,5) convolutional codec.
// Encoder and decoder both take branch labels from here.
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef logic [1:0] state_t;

   // Shift-register contents are {d, s1, s0}; the label bit order is {g7, g5}.
   function automatic logic [1:0] branch_label(input state_t state, input logic d);
      logic [2:0] sr;
      sr = {d, state};
      return {^(sr & G0), ^(sr & G1)};
   endfunction

   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return {x[1] & x[0], x[1] ^ x[0]};
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state: picks the smaller candidate metric.
// On a tie, candidate 0 (predecessor {a,0}) wins.
module viterbi_acs #(
   parameter int PM_W = 8
) (
   input  logic [PM_W-1:0] cand0,
   input  logic [PM_W-1:0] cand1,
   output logic [PM_W-1:0] pm_win,
   output logic            sel
);

   assign sel    = (cand1 < cand0);
   assign pm_win = sel ? cand1 : cand0;

endmodule

// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 convolutional encoder plus hard-decision register-exchange Viterbi decoder.
// Optional feature macro: VITERBI_BEST_METRIC_EN adds the best_metric_o output.
module viterbi_codec
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable_encoder_i,
   input  logic            encoder_i,
   output logic            valid_encoder_o,
   output logic [1:0]      encoder_o,
   input  logic            enable_decoder_i,
   input  logic [1:0]      decoder_i,
   output logic            valid_decoder_o,
   output logic            decoder_o
`ifdef VITERBI_BEST_METRIC_EN
   ,
   output logic [PM_W-1:0] best_metric_o
`endif
);

   localparam int CNT_W = $clog2(TB_DEPTH + 1);

   state_t enc_state;

   logic [NUM_STATES-1:0][PM_W-1:0]     pm_p0;
   logic [NUM_STATES-1:0][PM_W-1:0]     pm_nxt;
   logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_p0;
   logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_nxt;
   logic [NUM_STATES-1:0]               dec_sel;
   logic [CNT_W-1:0]                    cnt_p0;
   logic [PM_W-1:0]                     min_pm;
   state_t                              best;
   logic                                full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_state       <= '0;
         encoder_o       <= 2'b00;
         valid_encoder_o <= 1'b0;
      end else begin
         valid_encoder_o <= enable_encoder_i;
         if (enable_encoder_i) begin
            encoder_o <= branch_label(enc_state, encoder_i);
            enc_state <= {encoder_i, enc_state[1]};
         end
      end
   end

   // Best state by pre-update metric; strict compare keeps the lowest index on ties.
   always_comb begin
      min_pm = pm_p0[0];
      best   = '0;
      for (int s = 1; s < NUM_STATES; s++) begin
         if (pm_p0[s] < min_pm) begin
            min_pm = pm_p0[s];
            best   = state_t'(s);
         end
      end
   end

   assign full = (cnt_p0 == CNT_W'(TB_DEPTH));

   // Next state {d,a} is reached from {a,0} and {a,1}; metrics normalised by min_pm.
   for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
      localparam int   P0 = 2 * (ns % 2);
      localparam int   P1 = P0 + 1;
      localparam logic D  = 1'(ns / 2);

      logic [PM_W-1:0]     cand0;
      logic [PM_W-1:0]     cand1;
      logic [TB_DEPTH-1:0] surv_pred;

      assign cand0 = pm_p0[P0] + PM_W'(hamming2(decoder_i, branch_label(state_t'(P0), D))) - min_pm;
      assign cand1 = pm_p0[P1] + PM_W'(hamming2(decoder_i, branch_label(state_t'(P1), D))) - min_pm;

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .cand0  (cand0),
         .cand1  (cand1),
         .pm_win (pm_nxt[ns]),
         .sel    (dec_sel[ns])
      );

      assign surv_pred    = dec_sel[ns] ? surv_p0[P1] : surv_p0[P0];
      assign surv_nxt[ns] = {surv_pred[TB_DEPTH-2:0], D};
   end

   // Decoder register stage: metrics, survivors, counter and output advance together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            pm_p0[s] <= (s == 0) ? '0 : PM_W'(16);
         end
         surv_p0         <= '0;
         cnt_p0          <= '0;
         decoder_o       <= 1'b0;
         valid_decoder_o <= 1'b0;
      end else begin
         valid_decoder_o <= 1'b0;
         if (enable_decoder_i) begin
            pm_p0           <= pm_nxt;
            surv_p0         <= surv_nxt;
            decoder_o       <= surv_p0[best][TB_DEPTH-1];
            valid_decoder_o <= full;
            if (!full) begin
               cnt_p0 <= cnt_p0 + 1'b1;
            end
         end
      end
   end

`ifdef VITERBI_BEST_METRIC_EN
   logic [PM_W-1:0] min_nxt;

   always_comb begin
      min_nxt = pm_nxt[0];
      for (int s = 1; s < NUM_STATES; s++) begin
         if (pm_nxt[s] < min_nxt) min_nxt = pm_nxt[s];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_metric_o <= '0;
      end else if (enable_decoder_i) begin
         best_metric_o <= min_nxt;
      end
   end
`else
   // Without the feature there is no best-metric register or port.
`endif

endmodule

// File: tb/tb_viterbi_codec.sv
// Self-checking bench for viterbi_codec: random streams against a full-path trellis model.
module tb_viterbi_codec;

   localparam int TB = 16;
   localparam int PMW = 8;
   localparam int MAXN = 512;

   logic       clk;
   logic       rst;
   logic       enable_encoder_i;
   logic       encoder_i;
   logic       valid_encoder_o;
   logic [1:0] encoder_o;
   logic       enable_decoder_i;
   logic [1:0] decoder_i;
   logic       valid_decoder_o;
   logic       decoder_o;
`ifdef VITERBI_BEST_METRIC_EN
   logic [PMW-1:0] best_metric_o;
`endif

   int errors = 0;
   int checks = 0;

   logic [1:0] sym_arr [MAXN];
   logic       bits    [MAXN];
   logic       exp_dec [MAXN];
   logic       obs_vld [MAXN];
   logic       obs_bit [MAXN];
   int         gap_valid_hits;

   viterbi_codec #(.TB_DEPTH(TB), .PM_W(PMW)) dut (
      .clk              (clk),
      .rst              (rst),
      .enable_encoder_i (enable_encoder_i),
      .encoder_i        (encoder_i),
      .valid_encoder_o  (valid_encoder_o),
      .encoder_o        (encoder_o),
      .enable_decoder_i (enable_decoder_i),
      .decoder_i        (decoder_i),
      .valid_decoder_o  (valid_decoder_o),
      .decoder_o        (decoder_o)
`ifdef VITERBI_BEST_METRIC_EN
      ,
      .best_metric_o    (best_metric_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Encoder rule: output {d^s1^s0, d^s0} from state {s1,s0}.
   function automatic logic [1:0] enc_model(input logic d, input logic [1:0] s);
      return {d ^ s[1] ^ s[0], d ^ s[0]};
   endfunction

   // Random information bits plus their error-free code symbols starting from state 0.
   task automatic make_stream(input int n);
      logic [1:0] es;
      es = 2'b00;
      for (int i = 0; i < n; i++) begin
         bits[i]    = 1'($urandom_range(0, 1));
         sym_arr[i] = enc_model(bits[i], es);
         es         = {bits[i], es[1]};
      end
   endtask

   // Trellis search with unbounded metrics and complete path histories per state.
   task automatic model_decode(input int n);
      int          m  [4];
      int          nm [4];
      logic [MAXN-1:0] path [4];
      logic [MAXN-1:0] np   [4];
      int          b, p0, p1, c0, c1;
      logic        d;
      m = '{0, 16, 16, 16};
      for (int s = 0; s < 4; s++) path[s] = '0;
      for (int j = 0; j < n; j++) begin
         b = 0;
         for (int s = 1; s < 4; s++) if (m[s] < m[b]) b = s;
         exp_dec[j] = (j >= TB) ? path[b][j-TB] : 1'b0;
         for (int ns = 0; ns < 4; ns++) begin
            d  = (ns >= 2);
            p0 = 2 * (ns % 2);
            p1 = p0 + 1;
            c0 = m[p0] + $countones(sym_arr[j] ^ enc_model(d, p0[1:0]));
            c1 = m[p1] + $countones(sym_arr[j] ^ enc_model(d, p1[1:0]));
            if (c1 < c0) begin
               nm[ns] = c1;
               np[ns] = path[p1];
            end else begin
               nm[ns] = c0;
               np[ns] = path[p0];
            end
            np[ns][j] = d;
         end
         m    = nm;
         path = np;
      end
   endtask

   task automatic do_reset();
      enable_encoder_i = 1'b0;
      encoder_i        = 1'b0;
      enable_decoder_i = 1'b0;
      decoder_i        = 2'b00;
      rst              = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Feeds sym_arr[0..n-1] to the decoder, optionally idling gap_len of every gap_per cycles.
   task automatic drive_dec(input int n, input int gap_per, input int gap_len);
      int   k;
      int   c;
      logic en;
      k = 0;
      c = 0;
      gap_valid_hits = 0;
      while (k < n) begin
         en = !(gap_per > 0 && (c % gap_per) >= gap_per - gap_len);
         enable_decoder_i = en;
         decoder_i        = en ? sym_arr[k] : 2'($urandom_range(0, 3));
         @(posedge clk);
         #1;
         if (en) begin
            obs_vld[k] = valid_decoder_o;
            obs_bit[k] = decoder_o;
            k++;
         end else if (valid_decoder_o !== 1'b0) begin
            gap_valid_hits++;
         end
         c++;
      end
      enable_decoder_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (encoder_o !== 2'b00 || valid_encoder_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_encoder: encoder_o=%b valid=%b, required 00/0", encoder_o, valid_encoder_o);
      end
      checks++;
      if (decoder_o !== 1'b0 || valid_decoder_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_decoder: decoder_o=%b valid=%b, required 0/0", decoder_o, valid_decoder_o);
      end
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (dut.pm_p0[s] !== ((s == 0) ? PMW'(0) : PMW'(16))) begin
            errors++;
            $display("FAIL reset_pm%0d: got %0d, required %0d", s, dut.pm_p0[s], (s == 0) ? 0 : 16);
         end
      end
   endtask

   task automatic test_encoder_impulse();
      logic       seq [6];
      logic [1:0] es;
      logic [1:0] exp_sym;
      seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      es  = 2'b00;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         enable_encoder_i = 1'b1;
         encoder_i        = seq[i];
         exp_sym          = enc_model(seq[i], es);
         es               = {seq[i], es[1]};
         @(posedge clk);
         #1;
         checks++;
         if (encoder_o !== exp_sym || valid_encoder_o !== 1'b1) begin
            errors++;
            $display("FAIL enc_impulse[%0d]: got %b/%b, required %b/1", i, encoder_o, valid_encoder_o, exp_sym);
         end
      end
      enable_encoder_i = 1'b0;
      encoder_i        = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (encoder_o !== exp_sym || valid_encoder_o !== 1'b0) begin
            errors++;
            $display("FAIL enc_hold: got %b/%b, required %b/0", encoder_o, valid_encoder_o, exp_sym);
         end
      end
   endtask

   task automatic test_loopback();
      localparam int N = 256;
      logic [1:0] es;
      logic [1:0] exp_sym;
      int         j;
      int         bad;
      make_stream(N);
      es  = 2'b00;
      bad = 0;
      do_reset();
      for (int i = 0; i <= N; i++) begin
         enable_encoder_i = (i < N);
         encoder_i        = (i < N) ? bits[i] : 1'b0;
         enable_decoder_i = valid_encoder_o;
         decoder_i        = encoder_o;
         if (i < N) begin
            exp_sym = enc_model(bits[i], es);
            es      = {bits[i], es[1]};
         end
         @(posedge clk);
         #1;
         if (i < N) begin
            checks++;
            if (encoder_o !== exp_sym || valid_encoder_o !== 1'b1) begin
               errors++;
               $display("FAIL loop_enc[%0d]: got %b/%b, required %b/1", i, encoder_o, valid_encoder_o, exp_sym);
            end
         end
         if (i >= 1) begin
            j = i - 1;
            checks++;
            if (j < TB) begin
               if (valid_decoder_o !== 1'b0) begin
                  errors++;
                  $display("FAIL loop_early_valid[%0d]: got %b, required 0", j, valid_decoder_o);
               end
            end else if (valid_decoder_o !== 1'b1 || decoder_o !== bits[j-TB]) begin
               errors++;
               bad++;
               if (bad < 10)
                  $display("FAIL loop_dec[%0d]: got %b/%b, required 1/%b", j, valid_decoder_o, decoder_o, bits[j-TB]);
            end
         end
      end
      enable_encoder_i = 1'b0;
      enable_decoder_i = 1'b0;
   endtask

   // Compares the decoder run captured by drive_dec with the reference sequence.
   task automatic test_error_injection();
      localparam int N = 256;
      int residual;
      make_stream(N);
      for (int j = 0; j < N; j++) begin
         if ((j % 32) >= 5 && (j % 32) < 9) sym_arr[j] = sym_arr[j] ^ 2'b10;
      end
      model_decode(N);
      residual = 0;
      for (int j = TB; j < N; j++) if (exp_dec[j] !== bits[j-TB]) residual++;
      $display("error injection: reference decoder leaves %0d residual bit errors", residual);
      do_reset();
      drive_dec(N, 0, 0);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (j < TB) begin
            if (obs_vld[j] !== 1'b0) begin
               errors++;
               $display("FAIL inj_early_valid[%0d]: got %b, required 0", j, obs_vld[j]);
            end
         end else if (obs_vld[j] !== 1'b1 || obs_bit[j] !== exp_dec[j]) begin
            errors++;
            $display("FAIL inj_dec[%0d]: got %b/%b, required 1/%b", j, obs_vld[j], obs_bit[j], exp_dec[j]);
         end
      end
   endtask

   // Reuses the injected stream and reference from the previous test, now with enable gaps.
   task automatic test_enable_gaps();
      localparam int N = 256;
      do_reset();
      drive_dec(N, 10, 3);
      checks++;
      if (gap_valid_hits !== 0) begin
         errors++;
         $display("FAIL gap_valid: valid seen in %0d gap cycles, required 0", gap_valid_hits);
      end
      for (int j = 0; j < N; j++) begin
         checks++;
         if (j < TB) begin
            if (obs_vld[j] !== 1'b0) begin
               errors++;
               $display("FAIL gap_early_valid[%0d]: got %b, required 0", j, obs_vld[j]);
            end
         end else if (obs_vld[j] !== 1'b1 || obs_bit[j] !== exp_dec[j]) begin
            errors++;
            $display("FAIL gap_dec[%0d]: got %b/%b, required 1/%b", j, obs_vld[j], obs_bit[j], exp_dec[j]);
         end
      end
   endtask

   task automatic test_mid_reset();
      localparam int N = 48;
      make_stream(N);
      do_reset();
      enable_encoder_i = 1'b1;
      encoder_i        = 1'b1;
      drive_dec(N, 0, 0);
      enable_decoder_i = 1'b1;
      decoder_i        = 2'b11;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (encoder_o !== 2'b00 || valid_encoder_o !== 1'b0 || decoder_o !== 1'b0 || valid_decoder_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: enc=%b/%b dec=%b/%b, required all 0",
                  encoder_o, valid_encoder_o, decoder_o, valid_decoder_o);
      end
      checks++;
      if (dut.pm_p0[0] !== PMW'(0) || dut.pm_p0[3] !== PMW'(16)) begin
         errors++;
         $display("FAIL midreset_pm: pm0=%0d pm3=%0d, required 0/16", dut.pm_p0[0], dut.pm_p0[3]);
      end
      enable_encoder_i = 1'b0;
      enable_decoder_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      make_stream(N);
      model_decode(N);
      drive_dec(N, 0, 0);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (j < TB) begin
            if (obs_vld[j] !== 1'b0) begin
               errors++;
               $display("FAIL midreset_early_valid[%0d]: got %b, required 0", j, obs_vld[j]);
            end
         end else if (obs_vld[j] !== 1'b1 || obs_bit[j] !== bits[j-TB] || obs_bit[j] !== exp_dec[j]) begin
            errors++;
            $display("FAIL midreset_dec[%0d]: got %b/%b, required 1/%b", j, obs_vld[j], obs_bit[j], bits[j-TB]);
         end
      end
   endtask

   initial begin
      rst              = 1'b0;
      enable_encoder_i = 1'b0;
      encoder_i        = 1'b0;
      enable_decoder_i = 1'b0;
      decoder_i        = 2'b00;
      test_reset();
      test_encoder_impulse();
      test_loopback();
      test_error_injection();
      test_enable_gaps();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
